simple_prog_loader: RTL

SIMPLE_PROG_LOADER -- requirements
Module: simple_prog_loader

---
 rtl/simple_prog_loader.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/simple_prog_loader.sv
// simple_prog_loader: receives a length-prefixed, XOR-checksummed byte stream and writes it
// into instruction memory as 16-bit words. The CPU is held in reset until a load
// finishes with a good checksum.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       synchronous, active-high reset
//   start       single-cycle request to begin a load (honoured in IDLE or DONE only)
//   in_valid    byte-stream valid
//   in_data     byte-stream data
//   in_ready    byte-stream ready; a byte transfers when in_valid and in_ready are high
//   imem_wren   instruction-memory write enable (one-cycle pulse per word)
//   imem_waddr  instruction word address
//   imem_wdata  instruction word, first received byte in bits 15:8
//   cpu_hold    holds the CPU in reset while high
//   busy        a load is in progress
//   done        the last load finished (level)
//   err         the last load failed its checksum; valid while done is high
module simple_prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wren,
    output logic [7:0]  imem_waddr,
    output logic [15:0] imem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StHi,
        StLo,
        StCsum,
        StDone
    } state_t;

    state_t      state_q, state_d;
    logic [8:0]  remain_q;   // words still to be written, 1..256
    logic [7:0]  addr_q;     // address of the next word to write
    logic [7:0]  hi_q;
    logic [7:0]  csum_q;
    logic [7:0]  waddr_q;
    logic [15:0] wdata_q;
    logic        wren_q;
    logic        err_q;
    logic        accept;

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) state_d = StLen;
            end
            StLen: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StHi;
            end
            StHi: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StLo;
            end
            StLo: begin
                in_ready = 1'b1;
                // remain_q still counts the word being accepted here
                if (in_valid) state_d = (remain_q > 9'd1) ? StHi : StCsum;
            end
            StCsum: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        accept = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            remain_q <= 9'd0;
            addr_q   <= 8'd0;
            hi_q     <= 8'd0;
            csum_q   <= 8'd0;
            waddr_q  <= 8'd0;
            wdata_q  <= 16'd0;
            wren_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wren_q  <= 1'b0;
            // Bookkeeping for the word written this cycle
            if (wren_q) begin
                addr_q   <= addr_q + 8'd1;
                remain_q <= remain_q - 9'd1;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        csum_q <= 8'd0;
                        err_q  <= 1'b0;
                    end
                end
                StLen: begin
                    if (accept) begin
                        remain_q <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                        addr_q   <= 8'd0;
                        csum_q   <= csum_q ^ in_data;
                    end
                end
                StHi: begin
                    if (accept) begin
                        hi_q   <= in_data;
                        csum_q <= csum_q ^ in_data;
                    end
                end
                StLo: begin
                    if (accept) begin
                        wdata_q <= {hi_q, in_data};
                        waddr_q <= addr_q;
                        wren_q  <= 1'b1;
                        csum_q  <= csum_q ^ in_data;
                    end
                end
                StCsum: begin
                    if (accept) err_q <= (in_data != csum_q);
                end
                default: ;
            endcase
        end
    end

    // Reset in the pulse cycle suppresses the pending write
    assign imem_wren  = wren_q & ~reset;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == StLen) || (state_q == StHi) ||
                        (state_q == StLo)  || (state_q == StCsum);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign cpu_hold   = !((state_q == StDone) && !err_q);

endmodule
